// File: rtl/sprite_engine.sv
// sprite_engine: hardware sprite compositor for a VGA scan-out.
//
// For every scan coordinate (x, y) it checks each sprite channel for
// coverage, issues a per-channel image ROM address, and picks the
// lowest-index opaque pixel once the ROM data returns. The pipeline never
// stalls and its latency is fixed at 2 + ROM_LAT cycles.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   x, y              current scan coordinate
//   frame_start       one-cycle pulse; latches sprite state, rolls collision
//   spr_x, spr_y      per-channel top-left position, 10 bits per channel
//   spr_en, spr_flip  per-channel enable and horizontal mirror
//   rom_addr          per-channel ROM address {row, col}
//   rom_data          per-channel ROM pixel, ROM_LAT cycles after rom_addr
//   pix_color         winning pixel colour, 8'h00 when no sprite is opaque
//   pix_hit           an opaque sprite pixel was selected
//   hit_id            index of the winning channel, 0 without a hit
//   collision         sticky per-frame flag: two or more opaque sprites met
//   last_collision    collision value captured at the latest frame_start
module sprite_engine #(
  parameter int unsigned NUM_SPR = 2,
  parameter int unsigned SW_LOG2 = 6,
  parameter int unsigned SH_LOG2 = 6,
  parameter int unsigned ROM_LAT = 1,
  parameter logic [7:0]  TRANSP  = 8'h00
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [9:0]                           x,
  input  logic [9:0]                           y,
  input  logic                                 frame_start,
  input  logic [NUM_SPR*10-1:0]                spr_x,
  input  logic [NUM_SPR*10-1:0]                spr_y,
  input  logic [NUM_SPR-1:0]                   spr_en,
  input  logic [NUM_SPR-1:0]                   spr_flip,
  output logic [NUM_SPR*(SH_LOG2+SW_LOG2)-1:0] rom_addr,
  input  logic [NUM_SPR*8-1:0]                 rom_data,
  output logic [7:0]                           pix_color,
  output logic                                 pix_hit,
  output logic [2:0]                           hit_id,
  output logic                                 collision,
  output logic                                 last_collision
);

  localparam int unsigned AW    = SH_LOG2 + SW_LOG2;
  localparam logic [10:0] SPR_W = 11'(1 << SW_LOG2);
  localparam logic [10:0] SPR_H = 11'(1 << SH_LOG2);

  // Shadow copies: sprite state only moves at frame boundaries.
  logic [NUM_SPR*10-1:0] sh_x_q, sh_y_q;
  logic [NUM_SPR-1:0]    sh_en_q, sh_flip_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_x_q    <= '0;
      sh_y_q    <= '0;
      sh_en_q   <= '0;
      sh_flip_q <= '0;
    end else if (frame_start) begin
      sh_x_q    <= spr_x;
      sh_y_q    <= spr_y;
      sh_en_q   <= spr_en;
      sh_flip_q <= spr_flip;
    end
  end

  // Stage 1: coverage test and ROM address per channel.
  logic [NUM_SPR-1:0]    in_range_d, in_range_q;
  logic [NUM_SPR*AW-1:0] rom_addr_d;

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_stage1
    logic [10:0]        dx, dy;
    logic [SW_LOG2-1:0] col;

    // 11-bit differences: a coordinate left of / above the sprite wraps to a
    // large value and fails the range test, so sprites clip instead of wrap.
    assign dx  = {1'b0, x} - {1'b0, sh_x_q[10*i +: 10]};
    assign dy  = {1'b0, y} - {1'b0, sh_y_q[10*i +: 10]};
    // (2^SW_LOG2 - 1) - c is the bitwise complement of c
    assign col = sh_flip_q[i] ? ~dx[SW_LOG2-1:0] : dx[SW_LOG2-1:0];

    assign in_range_d[i]              = sh_en_q[i] & (dx < SPR_W) & (dy < SPR_H);
    assign rom_addr_d[AW*i +: AW]     = {dy[SH_LOG2-1:0], col};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_range_q <= '0;
      rom_addr   <= '0;
    end else begin
      in_range_q <= in_range_d;
      rom_addr   <= rom_addr_d;
    end
  end

  // Align the coverage flags with the ROM read latency.
  logic [NUM_SPR-1:0] in_range_al;

  if (ROM_LAT == 0) begin : g_no_dly
    assign in_range_al = in_range_q;
  end else begin : g_dly
    logic [NUM_SPR-1:0] dly_q [ROM_LAT];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int unsigned k = 0; k < ROM_LAT; k++) dly_q[k] <= '0;
      end else begin
        dly_q[0] <= in_range_q;
        for (int unsigned k = 1; k < ROM_LAT; k++) dly_q[k] <= dly_q[k-1];
      end
    end

    assign in_range_al = dly_q[ROM_LAT-1];
  end

  // Output stage: priority select. Scanning downwards lets the lowest index
  // overwrite, and any earlier find means at least two opaque channels.
  logic [7:0] color_d;
  logic       hit_d;
  logic [2:0] id_d;
  logic       multi_d;

  always_comb begin
    color_d = '0;
    hit_d   = 1'b0;
    id_d    = '0;
    multi_d = 1'b0;
    for (int i = int'(NUM_SPR) - 1; i >= 0; i--) begin
      if (in_range_al[i] && (rom_data[8*i +: 8] != TRANSP)) begin
        if (hit_d) multi_d = 1'b1;
        color_d = rom_data[8*i +: 8];
        hit_d   = 1'b1;
        id_d    = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_color      <= '0;
      pix_hit        <= 1'b0;
      hit_id         <= '0;
      collision      <= 1'b0;
      last_collision <= 1'b0;
    end else begin
      pix_color <= color_d;
      pix_hit   <= hit_d;
      hit_id    <= id_d;
      // set wins over the frame_start clear
      collision <= multi_d | (collision & ~frame_start);
      if (frame_start) last_collision <= collision;
    end
  end

endmodule

// File: tb/tb_sprite_engine.sv
// Self-checking bench for sprite_engine at default parameters. A behavioural
// model works in plain integer screen coordinates; a queue of expected
// pixels models the fixed 3-cycle latency.
module tb_sprite_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic        frame_start = 1'b0;
  logic [19:0] spr_x = '0, spr_y = '0;
  logic [1:0]  spr_en = '0, spr_flip = '0;
  logic [23:0] rom_addr;
  logic [15:0] rom_data;
  logic [7:0]  pix_color;
  logic        pix_hit;
  logic [2:0]  hit_id;
  logic        collision, last_collision;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_engine dut (
    .clk            (clk),
    .reset          (reset),
    .x              (x),
    .y              (y),
    .frame_start    (frame_start),
    .spr_x          (spr_x),
    .spr_y          (spr_y),
    .spr_en         (spr_en),
    .spr_flip       (spr_flip),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .pix_color      (pix_color),
    .pix_hit        (pix_hit),
    .hit_id         (hit_id),
    .collision      (collision),
    .last_collision (last_collision)
  );

  // Image ROMs, one-cycle read latency.
  logic [7:0] rom_mem [2][4096];

  always @(posedge clk) begin
    rom_data[7:0]  <= rom_mem[0][rom_addr[11:0]];
    rom_data[15:8] <= rom_mem[1][rom_addr[23:12]];
  end

  typedef struct packed {
    logic [7:0] col;
    logic       hit;
    logic [2:0] id;
    logic       coll;
    logic       lcoll;
  } out_t;

  typedef struct packed {
    logic [7:0] col;
    logic       hit;
    logic [2:0] id;
    logic       multi;
  } ent_t;

  // Model state
  int   ms_x [2], ms_y [2];
  bit   ms_en [2], ms_flip [2];
  bit   coll_m, last_m;
  ent_t q [$];

  function automatic out_t obs();
    return {pix_color, pix_hit, hit_id, collision, last_collision};
  endfunction

  task automatic model_clear();
    q.delete();
    coll_m = 0;
    last_m = 0;
    for (int i = 0; i < 2; i++) begin
      ms_x[i] = 0; ms_y[i] = 0; ms_en[i] = 0; ms_flip[i] = 0;
    end
  endtask

  // Screen-space reference: which sprites cover (xv,yv), what they show.
  function automatic void ref_px(input int xv, input int yv, output ent_t e,
                                 output logic [23:0] addr);
    int dx, dy, c, r;
    logic [7:0] d;
    e    = '0;
    addr = '0;
    for (int i = 0; i < 2; i++) begin
      dx = xv - ms_x[i];
      dy = yv - ms_y[i];
      c  = dx & 63;
      r  = dy & 63;
      if (ms_flip[i]) c = 63 - c;
      addr[12*i +: 12] = 12'(r * 64 + c);
      d = rom_mem[i][r * 64 + c];
      if (ms_en[i] && dx >= 0 && dx < 64 && dy >= 0 && dy < 64 && d != 8'h00) begin
        if (e.hit) e.multi = 1'b1;
        else begin
          e.hit = 1'b1;
          e.col = d;
          e.id  = 3'(i);
        end
      end
    end
  endfunction

  // One clock: drive a coordinate, advance the model. ev marks that e holds
  // the expected outputs for the coordinate driven three cycles earlier;
  // ea is the expected rom_addr for the coordinate driven now.
  task automatic step(input int xv, input int yv, input bit fs, output bit ev,
                      output out_t e, output logic [23:0] ea);
    ent_t ne, oe;
    bit   multi;
    ref_px(xv, yv, ne, ea);
    q.push_back(ne);
    x = 10'(xv);
    y = 10'(yv);
    frame_start = fs;
    @(posedge clk);
    ev    = 0;
    multi = 0;
    oe    = '0;
    if (q.size() == 3) begin
      oe    = q.pop_front();
      ev    = 1;
      multi = oe.multi;
    end
    if (fs) begin
      last_m = coll_m;
      coll_m = multi;
      for (int i = 0; i < 2; i++) begin
        ms_x[i]    = int'(spr_x[10*i +: 10]);
        ms_y[i]    = int'(spr_y[10*i +: 10]);
        ms_en[i]   = spr_en[i];
        ms_flip[i] = spr_flip[i];
      end
    end else begin
      coll_m = coll_m | multi;
    end
    e = {oe.col, oe.hit, oe.id, coll_m, last_m};
    #1;
    frame_start = 1'b0;
  endtask

  task automatic set_rom(input int ch, input logic [7:0] v);
    for (int a = 0; a < 4096; a++) rom_mem[ch][a] = v;
  endtask

  // Drain the pipeline with all sprites disabled so ROM contents can change.
  task automatic quiesce();
    bit ev; out_t e; logic [23:0] ea;
    spr_en = 2'b00;
    step(0, 0, 1, ev, e, ea);
    for (int k = 0; k < 3; k++) step(0, 0, 0, ev, e, ea);
  endtask

  task automatic test_reset();
    bit ev; out_t e; logic [23:0] ea;
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({obs(), rom_addr} !== '0) begin
      errors++;
      $display("FAIL reset_async: got %h/%h required 0", obs(), rom_addr);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    set_rom(0, 8'h1C);
    set_rom(1, 8'h2D);
    // sprites enabled on the pins but not yet latched: nothing visible
    spr_x = {10'd100, 10'd100};
    spr_y = {10'd50, 10'd50};
    spr_en = 2'b11;
    for (int k = 0; k < 6; k++) begin
      step((k < 3) ? 100 + k : 0, 50, 0, ev, e, ea);
      if (ev) begin
        checks++;
        if (obs() !== e || pix_hit !== 1'b0) begin
          errors++;
          $display("FAIL reset_invisible: got %h required %h", obs(), e);
        end
      end
    end
  endtask

  task automatic test_basic();
    bit ev; out_t e; logic [23:0] ea;
    quiesce();
    set_rom(0, 8'h1C);
    set_rom(1, 8'h00);
    spr_x = {10'd500, 10'd100};
    spr_y = {10'd500, 10'd50};
    spr_en = 2'b01;
    spr_flip = 2'b00;
    step(0, 0, 1, ev, e, ea);
    step(100, 50, 0, ev, e, ea);
    checks++;
    if (rom_addr[11:0] !== 12'd0 || rom_addr !== ea) begin
      errors++;
      $display("FAIL basic_addr: got %h required %h", rom_addr, ea);
    end
    step(164, 50, 0, ev, e, ea);
    step(0, 0, 0, ev, e, ea);
    checks++;
    if (obs() !== e || pix_color !== 8'h1C || pix_hit !== 1'b1 || hit_id !== 3'd0) begin
      errors++;
      $display("FAIL basic_hit: got %h required %h", obs(), e);
    end
    step(0, 0, 0, ev, e, ea);
    checks++;
    if (obs() !== e || pix_hit !== 1'b0 || pix_color !== 8'h00) begin
      errors++;
      $display("FAIL basic_right_edge: got %h required %h", obs(), e);
    end
  endtask

  task automatic test_flip();
    bit ev; out_t e; logic [23:0] ea;
    spr_flip = 2'b01;
    spr_en   = 2'b01;
    step(0, 0, 1, ev, e, ea);
    step(100, 50, 0, ev, e, ea);
    checks++;
    if (rom_addr[11:0] !== {6'd0, 6'd63} || rom_addr !== ea) begin
      errors++;
      $display("FAIL flip_addr: got %h required %h", rom_addr[11:0], {6'd0, 6'd63});
    end
    step(0, 0, 0, ev, e, ea);
    step(0, 0, 0, ev, e, ea);
    checks++;
    if (obs() !== e || pix_hit !== 1'b1) begin
      errors++;
      $display("FAIL flip_px: got %h required %h", obs(), e);
    end
  endtask

  task automatic test_overlap();
    bit ev; out_t e; logic [23:0] ea;
    quiesce();
    set_rom(0, 8'h1C);
    set_rom(1, 8'h33);
    spr_x = {10'd200, 10'd200};
    spr_y = {10'd200, 10'd200};
    spr_en = 2'b11;
    spr_flip = 2'b00;
    step(0, 0, 1, ev, e, ea);
    step(210, 205, 0, ev, e, ea);
    step(0, 0, 0, ev, e, ea);
    step(0, 0, 0, ev, e, ea);
    checks++;
    if (obs() !== e || hit_id !== 3'd0 || pix_color !== 8'h1C || collision !== 1'b1) begin
      errors++;
      $display("FAIL overlap_hit: got %h required %h", obs(), e);
    end
    step(0, 0, 1, ev, e, ea);
    checks++;
    if (obs() !== e || last_collision !== 1'b1 || collision !== 1'b0) begin
      errors++;
      $display("FAIL overlap_roll: got %h required %h", obs(), e);
    end
  endtask

  task automatic test_transparent();
    bit ev; out_t e; logic [23:0] ea;
    quiesce();
    set_rom(0, 8'h00);
    set_rom(1, 8'h55);
    spr_en = 2'b11;
    step(0, 0, 1, ev, e, ea);
    step(205, 205, 0, ev, e, ea);
    step(0, 0, 0, ev, e, ea);
    step(0, 0, 0, ev, e, ea);
    checks++;
    if (obs() !== e || pix_color !== 8'h55 || hit_id !== 3'd1 || collision !== 1'b0) begin
      errors++;
      $display("FAIL transp_px: got %h required %h", obs(), e);
    end
  endtask

  task automatic test_same_cycle();
    bit ev; out_t e; logic [23:0] ea;
    quiesce();
    set_rom(0, 8'h1C);
    set_rom(1, 8'h33);
    spr_en = 2'b11;
    step(0, 0, 1, ev, e, ea);
    for (int k = 0; k < 3; k++) step(0, 0, 0, ev, e, ea);
    step(210, 210, 0, ev, e, ea);
    step(0, 0, 0, ev, e, ea);
    // frame_start lands on the overlap's output-stage cycle
    step(0, 0, 1, ev, e, ea);
    checks++;
    if (obs() !== e || collision !== 1'b1 || last_collision !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_set: got %h required %h", obs(), e);
    end
    step(0, 0, 1, ev, e, ea);
    checks++;
    if (obs() !== e || collision !== 1'b0 || last_collision !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_next: got %h required %h", obs(), e);
    end
  endtask

  task automatic test_clip_shadow();
    bit ev; out_t e; logic [23:0] ea;
    int xs [12] = '{0, 5, 1010, 0, 1010, 305, 0, 0, 0, 305, 0, 0};
    int ys [12] = '{0, 10, 10, 0, 10, 10, 0, 0, 0, 10, 0, 0};
    bit fs [12] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int eh [12] = '{-1, -1, -1, 0, 1, -1, 1, 0, -1, -1, -1, 1};
    quiesce();
    set_rom(0, 8'h1C);
    set_rom(1, 8'h00);
    spr_x = {10'd0, 10'd1000};
    spr_y = {10'd0, 10'd0};
    spr_en = 2'b01;
    for (int k = 0; k < 12; k++) begin
      if (k == 4) spr_x[9:0] = 10'd300;   // mid-frame move must not show yet
      step(xs[k], ys[k], fs[k], ev, e, ea);
      if (ev) begin
        checks++;
        if (obs() !== e || (eh[k] >= 0 && pix_hit !== eh[k][0])) begin
          errors++;
          $display("FAIL clip_shadow[%0d]: got %h required %h hit %0d", k, obs(), e, eh[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit ev; out_t e; logic [23:0] ea;
    int xv, yv, s;
    quiesce();
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 4096; a++)
        rom_mem[c][a] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    for (int k = 0; k < 800; k++) begin
      if (k % 40 == 0) begin
        spr_x[9:0]   = 10'($urandom_range(0, 1023));
        spr_y[9:0]   = 10'($urandom_range(0, 1023));
        spr_x[19:10] = 10'((int'(spr_x[9:0]) + $urandom_range(0, 40)) % 1024);
        spr_y[19:10] = 10'((int'(spr_y[9:0]) + $urandom_range(0, 40)) % 1024);
        spr_en   = 2'($urandom_range(0, 3));
        spr_flip = 2'($urandom_range(0, 3));
        if (spr_en == 2'b00) spr_en = 2'b11;
      end
      s  = $urandom_range(0, 1);
      xv = ms_x[s] + $urandom_range(0, 80) - 8;
      yv = ms_y[s] + $urandom_range(0, 80) - 8;
      if ($urandom_range(0, 9) == 0) begin
        xv = $urandom_range(0, 1023);
        yv = $urandom_range(0, 1023);
      end
      xv = (xv < 0) ? 0 : ((xv > 1023) ? 1023 : xv);
      yv = (yv < 0) ? 0 : ((yv > 1023) ? 1023 : yv);
      step(xv, yv, (k % 40 == 1) || ($urandom_range(0, 59) == 0), ev, e, ea);
      checks++;
      if (rom_addr !== ea) begin
        errors++;
        $display("FAIL rand_addr[%0d]: got %h required %h", k, rom_addr, ea);
      end
      if (ev) begin
        checks++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL rand_px[%0d]: got %h required %h", k, obs(), e);
        end
      end
    end
  endtask

  task automatic test_reset_midscan();
    bit ev; out_t e; logic [23:0] ea;
    quiesce();
    set_rom(0, 8'h1C);
    set_rom(1, 8'h33);
    spr_x = {10'd200, 10'd200};
    spr_y = {10'd200, 10'd200};
    spr_en = 2'b11;
    step(0, 0, 1, ev, e, ea);
    step(210, 210, 0, ev, e, ea);
    step(0, 0, 0, ev, e, ea);
    step(0, 0, 0, ev, e, ea);
    checks++;
    if (collision !== 1'b1 || obs() !== e) begin
      errors++;
      $display("FAIL midscan_pre: got %h required %h", obs(), e);
    end
    step(211, 210, 0, ev, e, ea);   // leave a hit in flight
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({obs(), rom_addr} !== '0) begin
      errors++;
      $display("FAIL midscan_async: got %h/%h required 0", obs(), rom_addr);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    for (int k = 0; k < 5; k++) begin
      step(210, 210, 0, ev, e, ea);
      if (ev) begin
        checks++;
        if (obs() !== e || pix_hit !== 1'b0) begin
          errors++;
          $display("FAIL midscan_invisible: got %h required %h", obs(), e);
        end
      end
    end
    step(0, 0, 1, ev, e, ea);
    step(210, 210, 0, ev, e, ea);
    step(0, 0, 0, ev, e, ea);
    step(0, 0, 0, ev, e, ea);
    checks++;
    if (obs() !== e || pix_hit !== 1'b1 || collision !== 1'b1) begin
      errors++;
      $display("FAIL midscan_after_frame: got %h required %h", obs(), e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flip();
    test_overlap();
    test_transparent();
    test_same_cycle();
    test_clip_shadow();
    test_random();
    test_reset_midscan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
